// File: rtl/uart_rx_deserializer.sv
// Receive-side 8N1 UART front end: synchronises the raw RX pin, recovers
// each byte by mid-bit sampling and hands it to the core over a valid/ready
// holding register, with one-cycle framing-error and overrun pulses.
module uart_rx_deserializer #(
  parameter int CLKS_PER_BIT = 138
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       uart_line_in,
  output logic [7:0] data_out,
  output logic       data_valid,
  input  logic       data_ready,
  output logic       framing_error,
  output logic       overrun
);

  localparam int HALF  = (CLKS_PER_BIT - 1) / 2;
  localparam int CNT_W = $clog2(CLKS_PER_BIT);

  localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(HALF);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } state_t;

  state_t           state;
  logic             sync1;
  logic             sync2;
  logic [CNT_W-1:0] bit_cnt;
  logic [7:0]       shift_reg;
  logic [2:0]       bit_idx;

  // Two-flop synchroniser; resets to the idle (high) line level.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments make sync2 take the old sync1, which
      // is what gives a genuine two-stage chain; blocking would collapse it.
      sync1 <= uart_line_in;
      sync2 <= sync1;
    end
  end

  // Frame FSM, bit timer, shift register and the valid/ready holding register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state         <= IDLE;
      bit_cnt       <= '0;
      shift_reg     <= 8'h00;
      bit_idx       <= 3'd0;
      data_out      <= 8'h00;
      data_valid    <= 1'b0;
      framing_error <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      framing_error <= 1'b0;
      overrun       <= 1'b0;
      bit_cnt       <= bit_cnt + 1'b1;

      // NOTE: this consume is a default; a byte loaded in STOP below assigns
      // data_valid later in the block, and the last non-blocking write wins.
      if (data_valid && data_ready) begin
        data_valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (!sync2) begin
            state   <= START;
            bit_cnt <= '0;
          end
        end

        START: begin
          if (bit_cnt == HALF_CNT) begin
            bit_cnt <= '0;
            if (!sync2) begin
              state   <= DATA;
              bit_idx <= 3'd0;
            end else begin
              // Line went back high before mid start bit: a glitch.
              state <= IDLE;
            end
          end
        end

        DATA: begin
          if (bit_cnt == LAST_CNT) begin
            bit_cnt            <= '0;
            shift_reg[bit_idx] <= sync2;
            bit_idx            <= bit_idx + 1'b1;
            if (bit_idx == 3'd7) begin
              state <= STOP;
            end
          end
        end

        STOP: begin
          if (bit_cnt == LAST_CNT) begin
            bit_cnt <= '0;
            if (sync2) begin
              // Back to IDLE mid stop bit so a following start edge is seen.
              state <= IDLE;
              if (!data_valid || data_ready) begin
                data_out   <= shift_reg;
                data_valid <= 1'b1;
              end else begin
                overrun <= 1'b1;
              end
            end else begin
              framing_error <= 1'b1;
              state         <= WAIT_IDLE;
            end
          end
        end

        WAIT_IDLE: begin
          // Break or stuck-low line: wait silently for the line to recover.
          if (sync2) begin
            state   <= IDLE;
            bit_cnt <= '0;
          end
        end

        default: begin
          state   <= IDLE;
          bit_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Bench for uart_rx_deserializer at 16 clocks per bit. Frames are driven on
// the line, a frame-level model predicts when each byte lands and whether it
// is delivered, dropped (overrun) or rejected (framing error); a monitor
// compares DUT outputs against those predictions.
module tb_uart_rx_deserializer;

  localparam int C    = 16;
  localparam int HALF = (C - 1) / 2;
  // Edges from the first sync1 capture of the start bit to the byte landing.
  localparam int LAT  = 2 + (HALF + 1) + 9 * C;

  typedef struct {
    logic [7:0] data;
    int         edge_n;
    bit         stop_bad;
  } frame_t;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic       uart_line_in = 1'b1;
  logic [7:0] data_out;
  logic       data_valid;
  logic       data_ready = 1'b1;
  logic       framing_error;
  logic       overrun;

  // Stimulus-side controls (written by the main process only).
  bit ready_fixed = 1'b1;
  bit ready_rand  = 1'b0;
  bit done        = 1'b0;
  frame_t pending[$];

  // Model state (written by the model process only).
  int         edge_cnt = 0;
  int         p_rd = 0;
  bit         m_valid = 1'b0;
  logic [7:0] m_data = 8'h00;
  logic [7:0] exp_q[$];
  int         exp_ovr[$];
  int         exp_fe[$];

  // Monitor state.
  int n_cmp = 0;
  int n_bad = 0;
  int q_rd = 0;
  int o_rd = 0;
  int f_rd = 0;

  uart_rx_deserializer #(.CLKS_PER_BIT(C)) dut (
    .CLK           (CLK),
    .RST_N         (RST_N),
    .uart_line_in  (uart_line_in),
    .data_out      (data_out),
    .data_valid    (data_valid),
    .data_ready    (data_ready),
    .framing_error (framing_error),
    .overrun       (overrun)
  );

  always #5 CLK = ~CLK;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Consumer: fixed level, or bursty random ready for the soak test.
  initial begin
    bit slow = 1'b1;
    forever begin
      @(posedge CLK);
      #1;
      if ($urandom_range(0, 99) == 0) slow = ~slow;
      data_ready = ready_rand ? (slow && ($urandom_range(0, 3) != 0)) : ready_fixed;
    end
  end

  // Frame-level model: at each frame's landing edge decide its fate.
  initial begin
    bit accept;
    forever begin
      @(posedge CLK);
      edge_cnt++;
      if (!RST_N) begin
        m_valid = 1'b0;
        m_data  = 8'h00;
        p_rd    = pending.size();
      end else begin
        accept = m_valid && data_ready;
        if (accept) m_valid = 1'b0;
        if (p_rd < pending.size() && pending[p_rd].edge_n == edge_cnt) begin
          if (pending[p_rd].stop_bad) begin
            exp_fe.push_back(edge_cnt);
          end else if (!m_valid) begin
            m_valid = 1'b1;
            m_data  = pending[p_rd].data;
            exp_q.push_back(m_data);
          end else begin
            exp_ovr.push_back(edge_cnt);
          end
          p_rd++;
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at edge %0d: got %0h, expected %0h", name, edge_cnt, act, exp);
    end
  endtask

  // Monitor: compares outputs mid-cycle, pops the scoreboard on handshakes.
  initial begin
    forever begin
      @(negedge CLK);
      if (done) break;
      if (!RST_N) begin
        check("rst_data_out", {24'd0, data_out}, 32'd0);
        check("rst_data_valid", {31'd0, data_valid}, 32'd0);
        check("rst_framing_error", {31'd0, framing_error}, 32'd0);
        check("rst_overrun", {31'd0, overrun}, 32'd0);
      end else begin
        check("data_valid", {31'd0, data_valid}, {31'd0, m_valid});
        check("data_out", {24'd0, data_out}, {24'd0, m_data});
        check("fe_ovr_exclusive", {31'd0, framing_error & overrun}, 32'd0);
        if (data_valid && data_ready) begin
          if (q_rd < exp_q.size()) begin
            check("accepted_byte", {24'd0, data_out}, {24'd0, exp_q[q_rd]});
            q_rd++;
          end else begin
            check("unexpected_accept", 32'd1, 32'd0);
          end
        end
        if (overrun) begin
          if (o_rd < exp_ovr.size()) begin
            check("overrun_edge", edge_cnt, exp_ovr[o_rd]);
            o_rd++;
          end else begin
            check("spurious_overrun", 32'd1, 32'd0);
          end
        end else if (o_rd < exp_ovr.size() && exp_ovr[o_rd] <= edge_cnt) begin
          check("missing_overrun", 32'd0, 32'd1);
          o_rd++;
        end
        if (framing_error) begin
          if (f_rd < exp_fe.size()) begin
            check("framing_error_edge", edge_cnt, exp_fe[f_rd]);
            f_rd++;
          end else begin
            check("spurious_framing_error", 32'd1, 32'd0);
          end
        end else if (f_rd < exp_fe.size() && exp_fe[f_rd] <= edge_cnt) begin
          check("missing_framing_error", 32'd0, 32'd1);
          f_rd++;
        end
      end
    end
    check("all_bytes_consumed", q_rd, exp_q.size());
    check("all_overruns_seen", o_rd, exp_ovr.size());
    check("all_framing_errors_seen", f_rd, exp_fe.size());
    check("all_frames_resolved", p_rd, pending.size());
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Wait n edges and return 2 time units after the edge (drive point).
  task automatic idle(input int n);
    if (n > 0) begin
      repeat (n) @(posedge CLK);
      #2;
    end
  endtask

  // Drive one 8N1 frame starting now; optionally reset during data bit abort_bit.
  task automatic send_frame(input logic [7:0] b, input bit stop_val, input int abort_bit);
    frame_t f;
    f.data     = b;
    f.edge_n   = edge_cnt + 1 + LAT;
    f.stop_bad = !stop_val;
    pending.push_back(f);
    uart_line_in = 1'b0;
    idle(C);
    for (int i = 0; i < 8; i++) begin
      uart_line_in = b[i];
      if (i == abort_bit) begin
        idle(C / 2);
        RST_N = 1'b0;
        idle(4);
        uart_line_in = 1'b1;
        RST_N = 1'b1;
        return;
      end
      idle(C);
    end
    uart_line_in = stop_val;
    idle(C);
  endtask

  initial begin
    idle(3);
    RST_N = 1'b1;
    idle(5);

    // Single byte, consumer always ready.
    send_frame(8'h55, 1'b1, -1);
    idle(40);

    // Back-to-back frames with consumer stalled: second byte overruns.
    ready_fixed = 1'b0;
    idle(2);
    send_frame(8'hA3, 1'b1, -1);
    send_frame(8'h0F, 1'b1, -1);
    idle(40);
    ready_fixed = 1'b1;
    idle(1);
    ready_fixed = 1'b0;
    idle(10);
    ready_fixed = 1'b1;
    idle(10);

    // Short low glitch on an idle line, then a real frame.
    uart_line_in = 1'b0;
    idle(5);
    uart_line_in = 1'b1;
    idle(30);
    send_frame(8'h7E, 1'b1, -1);
    idle(40);

    // Bad stop bit followed by a long break, then recovery.
    send_frame(8'hC4, 1'b0, -1);
    idle(100);
    uart_line_in = 1'b1;
    idle(20);
    send_frame(8'h11, 1'b1, -1);
    idle(40);

    // Reset in the middle of data bit 4, then a clean frame.
    send_frame(8'h96, 1'b1, 4);
    idle(10);
    send_frame(8'h3C, 1'b1, -1);
    idle(40);

    // Random soak with a bursty consumer.
    ready_rand = 1'b1;
    for (int n = 0; n < 200; n++) begin
      send_frame(8'($urandom), 1'b1, -1);
      idle(($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 30));
    end
    ready_rand  = 1'b0;
    ready_fixed = 1'b1;
    idle(300);
    done = 1'b1;
  end

endmodule
